// File: rtl/wb_tg_pkg.sv
// Shared definitions for the Wishbone burst traffic generator.
//   - CTI / BTE encodings used on the initiator side
//   - FSM state encoding
//   - pat()         : address-derived test word
//   - bte_for_len() : burst type extension for a given burst length
package wb_tg_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_WR_GAP, ST_RD, ST_RD_GAP, ST_DONE
  } tg_state_e;

  // Only the low 16 address bits feed the pattern.
  function automatic logic [31:0] pat(input logic [15:0] a, input logic [31:0] seed);
    return {a, ~a} ^ seed;
  endfunction

  function automatic logic [1:0] bte_for_len(input int len);
    case (len)
      4:       return BTE_WRAP4;
      8:       return BTE_WRAP8;
      16:      return BTE_WRAP16;
      default: return BTE_LINEAR;
    endcase
  endfunction

endpackage

// File: rtl/wb_tg_checker.sv
// Read-back checker: compares each accepted read word against the expected
// pattern, keeps a saturating mismatch count and latches the first bad address.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   clr             clears count and captured address (new test)
//   chk_en          a read beat is being accepted this cycle
//   adr, dat_i      address and data of that beat
//   err_cnt         mismatch count, saturating
//   first_err_adr   address of the first mismatch
module wb_tg_checker
  import wb_tg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        chk_en,
  input  logic [29:0] adr,
  input  logic [31:0] dat_i,
  output logic [15:0] err_cnt,
  output logic [29:0] first_err_adr
);

  logic mis;
  assign mis = chk_en && (dat_i != pat(adr[15:0], SEED));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt       <= '0;
      first_err_adr <= '0;
    end else if (clr) begin
      err_cnt       <= '0;
      first_err_adr <= '0;
    end else if (mis) begin
      if (err_cnt == 16'h0)    first_err_adr <= adr;
      if (err_cnt != 16'hFFFF) err_cnt       <= err_cnt + 16'h1;
    end
  end

endmodule

// File: rtl/wb_burst_initiator.sv
// Wishbone B3 burst master used for memory self-test / traffic generation.
// Writes pat(adr) over NR_BURSTS bursts of BURST_LEN beats starting at
// ADR_BASE, reads the region back and checks every word.
// Ports:
//   wb_clk, wb_rst        clock / async active-low reset
//   start                 one-cycle pulse, ignored while busy
//   wbm_*                 Wishbone initiator port
//   busy, done, pass      test status
//   timeout               sticky, set when a slave stalls for TIMEOUT cycles
//   err_cnt               saturating mismatch count
//   first_err_adr         address of the first mismatch
module wb_burst_initiator
  import wb_tg_pkg::*;
#(
  parameter logic [29:0] ADR_BASE  = 30'h0,
  parameter int          BURST_LEN = 4,
  parameter int          NR_BURSTS = 16,
  parameter logic [31:0] SEED      = 32'h0,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        start,
  output logic [29:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [29:0] first_err_adr
);

  localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_W = $clog2(NR_BURSTS + 1);
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  tg_state_e          state, nxt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [WD_W-1:0]    wd_cnt;
  logic               timeout_q;
  logic               active, ack, last_beat, wd_expire, go, in_gap;
  logic [29:0]        cur_adr;

  // Bus outputs are decoded from the state register, so an async reset
  // drops cyc/stb in the same cycle.
  assign active    = (state == ST_WR) || (state == ST_RD);
  assign in_gap    = (state == ST_WR_GAP) || (state == ST_RD_GAP);
  assign ack       = active && wbm_ack_i;
  assign last_beat = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign wd_expire = active && !wbm_ack_i && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign go        = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign cur_adr   = ADR_BASE + 30'(burst_cnt) * 30'(BURST_LEN) + 30'(beat_cnt);

  assign timeout = timeout_q;
  assign pass    = done && (err_cnt == 16'h0) && !timeout_q;

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) state <= ST_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    done      = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_cti_o = CTI_CLASSIC;
    wbm_bte_o = BTE_LINEAR;
    case (state)
      ST_IDLE: if (go) nxt = ST_WR;
      ST_DONE: begin
        done = 1'b1;
        if (go) nxt = ST_WR;
      end
      ST_WR, ST_RD: begin
        busy      = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_we_o  = (state == ST_WR);
        wbm_adr_o = cur_adr;
        wbm_dat_o = (state == ST_WR) ? pat(cur_adr[15:0], SEED) : 32'h0;
        if (BURST_LEN > 1) begin
          wbm_cti_o = last_beat ? CTI_EOB : CTI_INC;
          wbm_bte_o = bte_for_len(BURST_LEN);
        end
        if (wd_expire)
          nxt = ST_DONE;
        else if (ack && last_beat)
          nxt = (state == ST_WR) ? ST_WR_GAP : ST_RD_GAP;
      end
      ST_WR_GAP: begin
        busy = 1'b1;
        nxt  = (burst_cnt < BURST_W'(NR_BURSTS)) ? ST_WR : ST_RD;
      end
      ST_RD_GAP: begin
        busy = 1'b1;
        nxt  = (burst_cnt < BURST_W'(NR_BURSTS)) ? ST_RD : ST_DONE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (go) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (ack) begin
        wd_cnt   <= '0;
        beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        if (last_beat) burst_cnt <= burst_cnt + BURST_W'(1);
      end else if (wd_expire) begin
        wd_cnt    <= '0;
        timeout_q <= 1'b1;
      end else if (active) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      // Burst count rolls over between the write and read phases.
      if (in_gap && (burst_cnt == BURST_W'(NR_BURSTS))) burst_cnt <= '0;
    end
  end

  wb_tg_checker #(.SEED(SEED)) u_chk (
    .clk           (wb_clk),
    .rst_n         (wb_rst),
    .clr           (go),
    .chk_en        (ack && (state == ST_RD)),
    .adr           (cur_adr),
    .dat_i         (wbm_dat_i),
    .err_cnt       (err_cnt),
    .first_err_adr (first_err_adr)
  );

endmodule

// File: doc/wb_burst_initiator.md
Name: wb_burst_initiator

Overview:
- Synthesizable Wishbone B3 burst master; drives one wbs port of versatile_mem_ctrl_top (the initiator end of that interface).
- On start: writes an address-derived pattern in NR_BURSTS incrementing/wrap bursts, reads the same region back and checks every word.
- Reports pass/fail, error count and the first failing address.
- Used for on-board memory self-test and as a synthesizable traffic source in simulation.

Parameters:
- ADR_BASE, 30'h0, word-address start of the region; must be BURST_LEN-aligned.
- BURST_LEN, 4, beats per burst; legal values 1, 4, 8, 16.
- NR_BURSTS, 16, bursts per phase (1..1024).
- SEED, 32'h0, XOR mask applied to the data pattern.
- TIMEOUT, 1024, wb_clk cycles allowed with stb_o high and no ack before abort.

Ports:
- wb_clk  in  1  clock; all logic on the rising edge.
- wb_rst  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse begins a test; ignored while busy.
- wbm_adr_o  out  30  word address, connects to wbsN_adr_i.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte selects.
- wbm_cti_o  out  3  cycle type identifier.
- wbm_bte_o  out  2  burst type extension.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  cycle valid.
- wbm_stb_o  out  1  strobe.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.
- busy  out  1  test in progress.
- done  out  1  test finished; held until the next accepted start.
- pass  out  1  done, no mismatches and no timeout.
- timeout  out  1  sticky; set on abort.
- err_cnt  out  16  mismatch count, saturates at 16'hFFFF.
- first_err_adr  out  30  address of the first mismatch.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0. Reset mid-burst drops cyc_o/stb_o immediately (asynchronous).
- Pattern: pat(a) = {a[15:0], ~a[15:0]} ^ SEED.
- FSM states: IDLE, WR, WR_GAP, RD, RD_GAP, DONE.
- IDLE: on start, go to WR; clear done, pass, timeout, err_cnt, first_err_adr; set busy.
- WR/RD:
  - cyc_o = stb_o = 1, sel_o = 4'hF; we_o = 1 in WR, 0 in RD.
  - Address = ADR_BASE + burst_cnt*BURST_LEN + beat_cnt.
  - Address, data, cti and bte are held stable until ack.
  - Each ack advances beat_cnt. The cycle after the ack presents the next beat, so zero wait states give one beat per clock.
- CTI/BTE:
  - BURST_LEN = 1: cti 3'b000, bte 2'b00.
  - Otherwise: cti 3'b010 on all beats except the last, which is 3'b111. bte is 01/10/11 for 4/8/16.
  - Alignment makes wrap identical to linear.
- End of burst (ack on the last beat):
  - Go to the GAP state for exactly one cycle with cyc_o = stb_o = 0; burst_cnt++.
  - From GAP: if burst_cnt < NR_BURSTS, return to the same phase; else clear burst_cnt and go from WR_GAP to RD, or from RD_GAP to DONE.
- Read check:
  - On each RD ack, compare wbm_dat_i with pat(adr).
  - Mismatch: err_cnt++ (saturating); capture first_err_adr only when err_cnt == 0.
- Watchdog:
  - Counter is cleared on every ack and increments while stb_o is high.
  - Reaching TIMEOUT: drop cyc_o/stb_o, set timeout, go to DONE.
- DONE: busy = 0, done = 1, pass = (err_cnt == 0) && !timeout. A start here re-runs the test (same as from IDLE).
- ack while stb_o is low is ignored.
- start while busy is ignored, with no effect on counters.

Decomposition:
- Package wb_tg_pkg:
  - CTI_CLASSIC/CTI_INC/CTI_EOB constants.
  - BTE_LINEAR/BTE_WRAP4/8/16 constants.
  - FSM state enum.
  - pattern function pat().
  - bte_for_len() function.
- Sub-module wb_tg_checker: compare, saturating err_cnt, first_err_adr capture. Inputs are check-enable, adr, dat_i and clear.

Test Plan:
- 0-wait memory slave, ADR_BASE=30'h100, BURST_LEN=4, NR_BURSTS=2, SEED=0:
  - Writes go to adr 0x100..0x107; adr 0x100 carries 32'h0100FEFF.
  - cti sequence per burst is 010,010,010,111; bte=01.
  - One idle cycle between bursts; then read back.
  - Result: done=1, pass=1, err_cnt=0.
- Slave with 3 wait states per beat: same result. Address, data and cti are held stable across the waits; total cycles scale accordingly.
- Slave flips bit 0 on reads of 0x105 and 0x106: err_cnt=2, first_err_adr=30'h105, pass=0.
- Slave never acks, TIMEOUT=16: 16 cycles after stb_o rises, cyc_o=0, timeout=1, done=1, pass=0.
- Reset asserted on the 3rd beat of a write burst: outputs go to 0 within the same cycle; after release, start re-runs cleanly and ends with pass=1.
- BURST_LEN=1: all beats use cti=000, bte=00. A start pulse during RD has no effect: err_cnt is unchanged and the test completes normally.
